tanhx_issue_ctrl: RTL and testbench

Streaming issue controller placed in front of the 16-segment tanh unit. It takes operands over a valid/ready input, drives the unit's `x_in`/`start` pins, and keeps `start` continuous until every real operand has left the pipeline. It captures the matching results in order into a credit-protected result FIFO and presents them over a valid/ready output. The unit has no backpressure, so this block is the only flow-control point for the tanh datapath.

---
 rtl/tanhx_issue_ctrl.sv | 154 +++++++++++++++
 tb/tb_tanhx_issue_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tanhx_issue_ctrl.sv
// Issue controller for the tanh unit: keeps start high across real operands plus pads,
// tracks real results through a tag pipe and buffers them in a credit-protected FIFO.
module tanhx_issue_ctrl #(
  parameter int DWIDTH  = 32,
  parameter int LATENCY = 3,
  parameter int DEPTH   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DWIDTH-1:0] s_data,
  output logic              s_ready,
  output logic [DWIDTH-1:0] x_out,
  output logic              start,
  input  logic [DWIDTH-1:0] y_in,
  input  logic              y_valid,
  output logic              m_valid,
  output logic [DWIDTH-1:0] m_data,
  input  logic              m_ready,
  output logic              busy,
  output logic              err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, COOL = 2'd2} state_t;

  state_t            state_q;
  logic [DWIDTH-1:0] x_q;
  logic              start_q;
  logic              real_q;
  logic [PW-1:0]     pads_q;
  logic [LATENCY-1:0] tag_q;
  logic [LATENCY-1:0] tag_d;
  logic [AW:0]       inflight_q;
  logic [AW:0]       inflight_d;
  logic [AW:0]       wr_q;
  logic [AW:0]       rd_q;
  logic [AW:0]       occ;
  logic [AW+1:0]     total;
  logic              err_q;
  logic              credit;
  logic              accept;
  logic              push;
  logic              pop;
  logic              empty;
  logic [DWIDTH-1:0] mem [DEPTH];

  // Credit covers everything accepted but not yet consumed, so the FIFO can never overflow.
  assign occ     = wr_q - rd_q;
  assign total   = {1'b0, occ} + {1'b0, inflight_q};
  assign credit  = total < (AW+2)'(DEPTH);
  assign s_ready = ~rst & credit & (state_q != COOL);
  assign accept  = s_valid & s_ready;
  assign push    = tag_q[LATENCY-1];
  assign empty   = (wr_q == rd_q);
  assign pop     = ~empty & m_ready;

  always_comb begin
    inflight_d = inflight_q;
    if (accept && !push) begin
      inflight_d = inflight_q + (AW+1)'(1);
    end else if (!accept && push) begin
      inflight_d = inflight_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      start_q <= 1'b0;
      real_q  <= 1'b0;
      pads_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          start_q <= 1'b0;
          real_q  <= 1'b0;
          if (accept) begin
            x_q     <= s_data;
            start_q <= 1'b1;
            real_q  <= 1'b1;
            pads_q  <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          start_q <= 1'b1;
          if (accept) begin
            x_q    <= s_data;
            real_q <= 1'b1;
            pads_q <= '0;
          end else begin
            // Zero pad keeps the unit streaming until all real tags have drained.
            x_q    <= '0;
            real_q <= 1'b0;
            if (pads_q == PW'(LATENCY)) begin
              start_q <= 1'b0;
              state_q <= COOL;
            end else begin
              pads_q <= pads_q + PW'(1);
            end
          end
        end
        default: begin
          start_q <= 1'b0;
          real_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        assign tag_d[gi] = start_q & real_q;
      end else begin : g_body
        assign tag_d[gi] = tag_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      if (push) wr_q <= wr_q + (AW+1)'(1);
      if (pop)  rd_q <= rd_q + (AW+1)'(1);
      if (push && !y_valid) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_q[AW-1:0]] <= y_in;
  end

  assign m_data  = mem[rd_q[AW-1:0]];
  assign m_valid = ~empty;
  assign busy    = (state_q != IDLE) | ~empty;
  assign err     = err_q;
  assign x_out   = x_q;
  assign start   = start_q;

endmodule

// File: tb/tb_tanhx_issue_ctrl.sv
// Bench for tanhx_issue_ctrl: behavioural tanh unit model, result scoreboard,
// table-driven issue patterns and hand-written corner-case sequences.
module tb_tanhx_issue_ctrl;
  localparam int DW = 32;
  localparam int L  = 3;
  localparam int D  = 8;
  localparam int HN = 4096;

  logic          clk, rst;
  logic          s_valid, s_ready;
  logic [DW-1:0] s_data, x_out, y_in, m_data;
  logic          start, y_valid, m_valid, m_ready, busy, err;

  tanhx_issue_ctrl #(.DWIDTH(DW), .LATENCY(L), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .x_out(x_out), .start(start), .y_in(y_in), .y_valid(y_valid),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Unit model: fixed-latency pipe, no backpressure, no reset.
  logic [DW-1:0] px [L];
  logic          ps [L];
  int            real_cnt = 0;
  int            drop_at  = -1;

  function automatic logic [DW-1:0] unit_f(input logic [DW-1:0] x);
    if (x == 32'h3F800000) return 32'h3F4C43EF;
    return x ^ 32'hA5A5A5A5;
  endfunction

  initial for (int k = 0; k < L; k++) begin px[k] = '0; ps[k] = 1'b0; end

  always @(posedge clk) begin
    px[0] <= x_out;
    ps[0] <= start;
    for (int k = 1; k < L; k++) begin
      px[k] <= px[k-1];
      ps[k] <= ps[k-1];
    end
    if (ps[L-1] && px[L-1] != 0) real_cnt <= real_cnt + 1;
  end

  assign y_in    = unit_f(px[L-1]);
  assign y_valid = ps[L-1] && !(px[L-1] != 0 && real_cnt + 1 == drop_at);

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard and per-cycle history, sampled on the falling edge.
  logic [DW-1:0] sb [$];
  logic start_h [HN];
  logic mv_h    [HN];
  logic err_h   [HN];
  logic pop_h   [HN];
  int acc_cnt = 0, pop_cnt = 0, max_out = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (cyc < HN) begin
        start_h[cyc] = start;
        mv_h[cyc]    = m_valid;
        err_h[cyc]   = err;
        pop_h[cyc]   = m_valid & m_ready;
      end
      if (s_valid && s_ready) acc_cnt++;
      if (m_valid && m_ready) begin
        pop_cnt++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL result_unexpected: got %h expected nothing (cycle %0d)", m_data, cyc);
        end else begin
          check("result", m_data, sb.pop_front());
        end
      end
      if (acc_cnt - pop_cnt > max_out) max_out = acc_cnt - pop_cnt;
    end
  end

  function automatic logic hget(input int which, input int i);
    if (i < 0 || i >= HN) return 1'bx;
    case (which)
      0: return start_h[i];
      1: return mv_h[i];
      2: return err_h[i];
      default: return pop_h[i];
    endcase
  endfunction

  function automatic int hcount(input int which, input int a, input int b);
    int c = 0;
    for (int i = a; i <= b; i++) if (hget(which, i) === 1'b1) c++;
    return c;
  endfunction

  task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] e, input int tmo,
                      output bit ok, output int acyc);
    s_valid = 1'b1;
    s_data  = d;
    ok      = 1'b0;
    acyc    = -1;
    for (int i = 0; i < tmo; i++) begin
      @(negedge clk);
      if (s_ready) begin
        ok   = 1'b1;
        acyc = cyc;
        sb.push_back(e);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    bit done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin done = 1'b1; break; end
    end
    check(nm, done, 1'b1);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [DW-1:0] data;
    int            gap;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n, n2, f, l, nacc;
    int ac [14];

    vecs[0]  = '{32'h11111111, 0, 32'hB4B4B4B4};
    vecs[1]  = '{32'h22222222, 0, 32'h87878787};
    vecs[2]  = '{32'h33333333, 0, 32'h96969696};
    vecs[3]  = '{32'h44444444, 0, 32'hE1E1E1E1};
    vecs[4]  = '{32'h12345678, 0, 32'hB791F3DD};
    vecs[5]  = '{32'hDEADBEEF, 0, 32'h7B081B4A};
    vecs[6]  = '{32'h40490FDB, 0, 32'hE5ECAA7E};
    vecs[7]  = '{32'hC0000000, 0, 32'h65A5A5A5};
    vecs[8]  = '{32'h0F0F0F0F, 1, 32'hAAAAAAAA};
    vecs[9]  = '{32'hF0F0F0F0, 1, 32'h55555555};
    vecs[10] = '{32'hAAAAAAAA, 1, 32'h0F0F0F0F};
    vecs[11] = '{32'h55555555, 1, 32'hF0F0F0F0};
    vecs[12] = '{32'h3F800000, 7, 32'h3F4C43EF};
    vecs[13] = '{32'hC0000000, 0, 32'h65A5A5A5};

    rst = 1'b1; s_valid = 1'b1; s_data = 32'h12345678; m_ready = 1'b1;
    idle(3);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_start", start, 1'b0);
    check("rst_x_out", x_out, 32'h0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    s_valid = 1'b0;
    rst = 1'b0;
    idle(2);

    // Single operand: result in n+5, start high n+1..n+4, COOL in n+5.
    send(32'h3F800000, 32'h3F4C43EF, 50, ok, n);
    s_valid = 1'b0;
    check("single_accept", ok, 1'b1);
    drain("single_drain");
    idle(4);
    for (int k = 1; k <= 4; k++) check("single_start_hi", hget(0, n + k), 1'b1);
    check("single_start_cool", hget(0, n + 5), 1'b0);
    check("single_mv_early", hget(1, n + 4), 1'b0);
    check("single_mv_n5", hget(1, n + 5), 1'b1);
    $display("[TB] single operand accepted cycle %0d", n);

    // Back-to-back burst of 8 from the table.
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].data, vecs[i].exp, 50, ok, ac[i]);
      $display("[TB] burst op %0d data %h accepted cycle %0d", i, vecs[i].data, ac[i]);
    end
    s_valid = 1'b0;
    drain("burst_drain");
    idle(3);
    f = ac[0]; l = ac[7];
    check("burst_b2b_accept", l - f, 7);
    check("burst_start_run", hcount(0, f + 1, l + 4), l + 4 - f);
    check("burst_cool", hget(0, l + 5), 1'b0);
    check("burst_b2b_results", hcount(3, f + 5, f + 12), 8);

    // Spaced issue (2 cycles apart) and then a long gap through COOL.
    for (int i = 8; i < 14; i++) begin
      send(vecs[i].data, vecs[i].exp, 50, ok, ac[i]);
      s_valid = 1'b0;
      $display("[TB] spaced op %0d data %h accepted cycle %0d", i, vecs[i].data, ac[i]);
      if (vecs[i].gap > 0) idle(vecs[i].gap);
    end
    drain("spaced_drain");
    idle(3);
    check("spaced_period", ac[11] - ac[8], 6);
    check("spaced_start_run", hcount(0, ac[8] + 1, ac[12] + 4), ac[12] + 4 - ac[8]);
    check("gap_cool", hget(0, ac[12] + 5), 1'b0);
    check("gap_restart", hget(0, ac[13] + 1), 1'b1);

    // Backpressure: m_ready low, only DEPTH operands accepted.
    m_ready = 1'b0;
    nacc = 0;
    for (int i = 0; i < 8; i++) begin
      send(32'h01000000 + i, (32'h01000000 + i) ^ 32'hA5A5A5A5, 20, ok, n);
      if (ok) nacc++;
    end
    check("bp_accepted8", nacc, 8);
    send(32'h01000008, 32'h01000008 ^ 32'hA5A5A5A5, 20, ok, n);
    check("bp_9th_blocked", ok, 1'b0);
    check("bp_s_ready_low", s_ready, 1'b0);
    check("bp_m_valid", m_valid, 1'b1);
    m_ready = 1'b1;
    for (int i = 8; i < 12; i++) begin
      send(32'h01000000 + i, (32'h01000000 + i) ^ 32'hA5A5A5A5, 100, ok, n);
      check("bp_resume_accept", ok, 1'b1);
      $display("[TB] backpressure op %0d accepted cycle %0d", i, n);
    end
    s_valid = 1'b0;
    drain("bp_drain");
    check("bp_no_overflow", (max_out <= D) ? 1'b1 : 1'b0, 1'b1);

    // Missing y_valid on the second real result.
    idle(2);
    drop_at = real_cnt + 2;
    send(32'h01010101, 32'h01010101 ^ 32'hA5A5A5A5, 50, ok, n);
    send(32'h02020202, 32'h02020202 ^ 32'hA5A5A5A5, 50, ok, n2);
    send(32'h03030303, 32'h03030303 ^ 32'hA5A5A5A5, 50, ok, n);
    s_valid = 1'b0;
    drain("err_drain");
    idle(2);
    drop_at = -1;
    check("err_before", hget(2, n2 + 4), 1'b0);
    check("err_set", hget(2, n2 + 5), 1'b1);
    check("err_sticky", err, 1'b1);
    $display("[TB] err test second op accepted cycle %0d", n2);

    // Asynchronous reset in the middle of a 5-operand burst.
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(32'h07000000 + i, (32'h07000000 + i) ^ 32'hA5A5A5A5, 50, ok, n);
    check("pre_rst_m_valid", m_valid, 1'b1);
    check("pre_rst_start", start, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_start", start, 1'b0);
    check("mid_rst_m_valid", m_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_err", err, 1'b0);
    check("mid_rst_x_out", x_out, 32'h0);
    sb.delete();
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    acc_cnt = 0; pop_cnt = 0;
    m_ready = 1'b1;
    idle(3);
    check("post_rst_empty", m_valid, 1'b0);
    check("post_rst_busy", busy, 1'b0);
    send(32'h3F800000, 32'h3F4C43EF, 50, ok, n);
    s_valid = 1'b0;
    check("post_rst_accept", ok, 1'b1);
    drain("post_rst_drain");
    idle(2);
    check("post_rst_mv_n5", hget(1, n + 5), 1'b1);
    check("post_rst_mv_early", hget(1, n + 4), 1'b0);
    check("final_sb_empty", sb.size(), 0);
    check("final_no_overflow", (max_out <= D) ? 1'b1 : 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
